jk_updown_counter: RTL

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

---
 rtl/jk_updown_counter_pkg.sv | 27 ++
 rtl/jk_updown_counter_jk_cell.sv | 46 ++++
 rtl/jk_updown_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/jk_updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// jk_updown_counter_pkg
// Shared definitions for the JK-based up/down modulo counter:
//   - default WIDTH / MODULUS of the counter
//   - JK excitation encoding {J,K}
//   - helper that derives the {J,K} pair that moves a cell from q to n
// -----------------------------------------------------------------------------
package jk_updown_counter_pkg;

   localparam int DEFAULT_WIDTH   = 4;
   localparam int DEFAULT_MODULUS = 10;

   // {J,K} encoding of a JK cell operation
   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_e;

   // Excitation that moves a cell from q to n using only SET/RESET/HOLD,
   // so the toggle code is never produced.
   function automatic logic [1:0] jk_excite(input logic q, input logic n);
      return {(~q & n), (q & ~n)};
   endfunction

endpackage

// File: rtl/jk_updown_counter_jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
// Single JK flip-flop with asynchronous active-low reset (clears to 0).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   j, k  - JK excitation inputs
//   q     - stored bit
// -----------------------------------------------------------------------------
module jk_cell
   import jk_updown_counter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_q;
   logic q_d;

   // JK next-state decode
   always_comb begin
      q_d = q_q;
      case ({j, k})
         JK_HOLD:   q_d = q_q;
         JK_RESET:  q_d = 1'b0;
         JK_SET:    q_d = 1'b1;
         JK_TOGGLE: q_d = ~q_q;
         default:   q_d = q_q;
      endcase
   end

   // Storage flop with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// -----------------------------------------------------------------------------
// jk_updown_counter
// Modulo-MODULUS up/down counter whose bits are held in JK cells.
// Priority per edge: load (clamped to MODULUS-1), then count, then hold.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (count=0, wrap=0)
//   en       - count enable
//   up       - direction, 1 = increment, 0 = decrement
//   load     - synchronous parallel load request
//   load_val - value to load (clamped to MODULUS-1)
//   count    - registered counter value
//   tc       - combinational terminal-count flag
//   wrap     - registered one-cycle pulse following a wrap-around edge
// -----------------------------------------------------------------------------
module jk_updown_counter
   import jk_updown_counter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = DEFAULT_MODULUS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(0);
   localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] jk_j_s;
   logic [WIDTH-1:0] jk_k_s;
   logic             tc_s;
   logic             wrap_q;
   logic             wrap_d;

   // Next count value: load (clamped) beats count, count beats hold
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (en) begin
         if (up) begin
            count_d = (count_q == MAX_VAL) ? ZERO_VAL : (count_q + ONE_VAL);
         end else begin
            count_d = (count_q == ZERO_VAL) ? MAX_VAL : (count_q - ONE_VAL);
         end
      end else begin
         count_d = count_q;
      end
   end

   // Terminal count only when this edge will actually wrap (a load masks it)
   always_comb begin
      tc_s = en & ~load &
             ((up & (count_q == MAX_VAL)) | (~up & (count_q == ZERO_VAL)));
   end

   // Per-bit JK excitation toward count_d
   always_comb begin
      jk_j_s = '0;
      jk_k_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {jk_j_s[i], jk_k_s[i]} = jk_excite(count_q[i], count_d[i]);
      end
   end

   // Wrap pulse is simply tc delayed by one edge
   always_comb begin
      wrap_d = tc_s;
   end

   // Wrap pulse register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (jk_j_s[g]),
         .k     (jk_k_s[g]),
         .q     (count_q[g])
      );
   end

   assign count = count_q;
   assign tc    = tc_s;
   assign wrap  = wrap_q;

endmodule
